data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 256, width of one memory line in bits.
REQ-002 Parameter DEPTH, default 512, number of lines; power of two.
REQ-003 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 Parameter LATENCY, default 10, clock cycles from request acceptance to ack; allowed range 2..255.
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 addr_i  input  ADDR_WIDTH  byte address of the requested line.
REQ-008 data_i  input  DATA_WIDTH  write data, one full line.
REQ-009 enable_i  input  1  request valid; held high by the requester until ack_o.
REQ-010 write_i  input  1  1 = write, 0 = read; qualified by enable_i.
REQ-011 ack_o  output  1  one-cycle completion pulse.
REQ-012 data_o  output  DATA_WIDTH  read data; valid only while ack_o = 1.

Function
REQ-013 Storage: array named memory, DEPTH x DATA_WIDTH, hierarchically accessible to benches for preload and inspection.
REQ-014 Line index = addr_i[log2(DEPTH)+4 : 5]; addr_i[4:0] ignored; higher bits ignored, so the index wraps modulo DEPTH.
REQ-015 FSM states: IDLE, WAIT, ACK.
REQ-016 IDLE: on a rising edge with enable_i = 1, latch index, data_i and write_i, clear the counter, and go to WAIT.
REQ-017 WAIT: counter increments each cycle; after LATENCY-1 cycles counted from acceptance, go to ACK.
REQ-018 ACK: ack_o = 1 for exactly one cycle, then return to IDLE.
REQ-019 Latency: request accepted at edge t -> ack_o high between edges t+LATENCY-1 and t+LATENCY.
REQ-020 Read: data_o = memory[latched index] during ACK; data_o = 0 in every other state.
REQ-021 Write: memory[latched index] <= latched data on the edge that ends ACK; data_o = 0 for writes.
REQ-022 Request inputs are ignored in WAIT and ACK; values latched at acceptance govern the transaction.
REQ-023 If enable_i is still high in the IDLE cycle after ACK, a new request is accepted; back-to-back accesses are spaced LATENCY+1 cycles apart.
REQ-024 Read-after-write to the same line returns the newly written data.
REQ-025 enable_i = 0 in IDLE: no state change, ack_o = 0.

Reset
REQ-026 rst_i = 1 immediately forces IDLE, counter = 0, ack_o = 0, data_o = 0.
REQ-027 Reset during WAIT or ACK aborts the transaction; a pending write is not committed.
REQ-028 memory contents are not affected by reset.

Structure
REQ-029 DATA_WIDTH, DEPTH, ADDR_WIDTH, LATENCY defaults and the FSM state encoding belong in the shared package, which the CPU and cache also use.
REQ-030 Single flat module with no sub-modules.

Verification
REQ-031 Preload memory[3] = 256'hA5 (repeating); read addr 0x60 -> ack_o high exactly 10 cycles after acceptance, data_o = preloaded line, then ack_o = 0 and data_o = 0.
REQ-032 Write addr 0x40 with data 256'h1234, then read addr 0x5F -> data_o = 256'h1234 (offset bits ignored).
REQ-033 Write addr 512*32 + 0x20 -> memory[1] is updated (index wraps modulo DEPTH).
REQ-034 enable_i held high across two reads -> two ack pulses 11 cycles apart, none in between.
REQ-035 Assert rst_i in cycle 5 of a write to line 7 -> no ack; memory[7] unchanged; the next request completes normally.
REQ-036 Change addr_i and write_i during WAIT -> the transaction uses the originally latched values.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Defaults and FSM encoding for the line-oriented data memory.
// The CPU and cache import this package as well.
package data_memory_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 256;
    localparam int unsigned DEFAULT_DEPTH      = 512;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_LATENCY    = 10;

    // Byte offset within one line; these address bits never select a line.
    localparam int unsigned LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } mem_state_e;

endpackage

// File: rtl/data_memory.sv
// Fixed-latency, line-wide data memory. A request is latched on acceptance, and
// ack_o pulses LATENCY cycles later. Writes commit on the edge that ends ACK.
import data_memory_pkg::*;

module data_memory #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned LATENCY    = DEFAULT_LATENCY
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LATENCY - 2);

    logic [DATA_WIDTH-1:0] memory [DEPTH];

    mem_state_e            state_q;
    logic [CNT_W-1:0]      count_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic [IDX_W-1:0]      idx_req;

    // Upper address bits are ignored so the index wraps modulo DEPTH.
    assign idx_req = addr_i[IDX_W+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];

    logic unused_addr;
    assign unused_addr = ^{addr_i[ADDR_WIDTH-1:IDX_W+LINE_OFFSET_BITS],
                           addr_i[LINE_OFFSET_BITS-1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            ack_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            ack_o  <= 1'b0;
            data_o <= '0;
            unique case (state_q)
                StIdle: begin
                    if (enable_i) begin
                        idx_q   <= idx_req;
                        wdata_q <= data_i;
                        write_q <= write_i;
                        count_q <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_WAIT) begin
                        state_q <= StAck;
                        ack_o   <= 1'b1;
                        data_o  <= write_q ? '0 : memory[idx_q];
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // No reset here: contents survive reset, and an aborted write never reaches ACK.
    always_ff @(posedge clk_i) begin
        if (state_q == StAck && write_q) begin
            memory[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: the driver queues the expected ack cycle and data,
// and the monitor checks every negedge.
module tb_data_memory;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 32;
    localparam int unsigned L  = 10;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        string         name;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_i;
    logic          enable_i;
    logic          write_i;
    logic          ack_o;
    logic [DW-1:0] data_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    data_memory #(
        .DATA_WIDTH(DW),
        .DEPTH     (512),
        .ADDR_WIDTH(AW),
        .LATENCY   (L)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .enable_i(enable_i),
        .write_i (write_i),
        .ack_o   (ack_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every ack must match the scoreboard head; idle cycles must show data_o = 0.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0) begin
            if (ack_o === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: ack at cycle %0d, none expected", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s_latency: ack at cycle %0d expected %0d", e.name, cyc, e.cyc);
                    end
                    check({e.name, "_data"}, data_o, e.data);
                end
            end else begin
                check("idle_data_zero", data_o, '0);
            end
        end
    end

    task automatic wait_ack(input string name);
        for (int i = 0; i < 4 * L; i++) begin
            @(negedge clk_i);
            if (ack_o === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: no ack within %0d cycles, expected one", name, 4 * L);
    endtask

    task automatic push(input string name, input logic [DW-1:0] d, input int at);
        exp_t e;
        e.data = d;
        e.cyc  = at;
        e.name = name;
        sb.push_back(e);
    endtask

    // Issue one request from an idle DUT; ack is expected L cycles after this negedge.
    task automatic do_req(input string name, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_d);
        @(negedge clk_i);
        addr_i   = a;
        data_i   = d;
        write_i  = wr;
        enable_i = 1'b1;
        push(name, exp_d, cyc + L);
        wait_ack(name);
        enable_i = 1'b0;
    endtask

    logic [DW-1:0] a5_line, line7_old, line12_old, d1234, dwrap, d10;

    initial begin
        a5_line    = {32{8'hA5}};
        line7_old  = {16{16'h7777}};
        line12_old = {8{32'hC0DE_0012}};
        d1234      = 256'h1234;
        dwrap      = {4{64'hDEAD_BEEF_0000_0001}};
        d10        = {2{128'h0A0A_5050_1234_5678_9ABC_DEF0_0F0F_F0F0}};
        addr_i   = '0;
        data_i   = '0;
        enable_i = 1'b0;
        write_i  = 1'b0;
        rst_i    = 1'b1;

        dut.memory[3]  = a5_line;
        dut.memory[7]  = line7_old;
        dut.memory[12] = line12_old;

        repeat (3) @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: got %b expected 0", ack_o);
        end
        check("reset_data", data_o, '0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Preloaded read, then write/read with offset bits ignored.
        do_req("read_0x60", 1'b0, 32'h60, '0, a5_line);
        do_req("write_0x40", 1'b1, 32'h40, d1234, '0);
        do_req("read_0x5F", 1'b0, 32'h5F, '0, d1234);

        // Index wraps modulo DEPTH.
        do_req("write_wrap", 1'b1, 32'd512 * 32 + 32'h20, dwrap, '0);
        @(negedge clk_i);
        check("wrap_mem1", dut.memory[1], dwrap);
        do_req("read_0x20", 1'b0, 32'h20, '0, dwrap);

        // enable_i held across two reads: second ack comes L+1 cycles after the first.
        @(negedge clk_i);
        addr_i   = 32'h60;
        write_i  = 1'b0;
        enable_i = 1'b1;
        push("b2b_first", a5_line, cyc + L);
        wait_ack("b2b_first");
        addr_i = 32'h40;
        push("b2b_second", d1234, cyc + L + 1);
        wait_ack("b2b_second");
        enable_i = 1'b0;

        // Reset in cycle 5 of a write to line 7 aborts it.
        @(negedge clk_i);
        addr_i   = 32'hE0;
        data_i   = {DW{1'b1}};
        write_i  = 1'b1;
        enable_i = 1'b1;
        repeat (4) @(negedge clk_i);
        rst_i    = 1'b1;
        enable_i = 1'b0;
        #1;
        checks++;
        if (ack_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_ack: got %b expected 0", ack_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2 * L) @(negedge clk_i);
        check("abort_mem7", dut.memory[7], line7_old);
        do_req("read_line7", 1'b0, 32'hE0, '0, line7_old);

        // Inputs changed during WAIT do not affect the latched request.
        @(negedge clk_i);
        addr_i   = 32'h140;
        data_i   = d10;
        write_i  = 1'b1;
        enable_i = 1'b1;
        push("latched_write", '0, cyc + L);
        repeat (3) @(negedge clk_i);
        addr_i  = 32'h180;
        write_i = 1'b0;
        data_i  = '0;
        wait_ack("latched_write");
        enable_i = 1'b0;
        @(negedge clk_i);
        check("latched_mem10", dut.memory[10], d10);
        check("latched_mem12", dut.memory[12], line12_old);
        do_req("read_line10", 1'b0, 32'h140, '0, d10);

        repeat (3) @(negedge clk_i);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_acks: %0d outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
